// File: rtl/rv32i_pkg.sv
// RV32I decode constants, immediate-format enum, ID/EX payload type and small decode helpers.
// Shared by the decode stage and its immediate generator.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1data;
        logic [31:0] rs2data;
        logic [31:0] imm;
        logic [4:0]  rd;
    } id_reg_t;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
        imm_fmt_e fmt;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    // x0 reads as zero; a same-cycle writeback to the read address wins over the stale array read.
    function automatic logic [31:0] sel_operand(input logic [4:0]  addr,
                                                input logic        wb_we,
                                                input logic [4:0]  wb_addr,
                                                input logic [31:0] wb_data,
                                                input logic [31:0] rf_data);
        logic [31:0] val;
        if (addr == 5'd0) begin
            val = 32'd0;
        end else if (wb_we && (wb_addr == addr)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: I/S/B/U/J formats sign-extended to 32 bits, zero for other opcodes.
// Purely combinational, no flow control.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    imm_fmt_e fmt;

    assign fmt = imm_fmt_of(instr_i[6:0]);

    always_comb begin
        imm_o = 32'd0;
        case (fmt)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'd0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: operand read with writeback bypass, immediate gen, load-use stall; 1-cycle latency.
// Backpressure: if_ready_o drops while ID/EX is held by execute, on load-use stall and on flush.
module decode_stage
    import rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic [4:0]  rf_raddra_o,
    output logic [4:0]  rf_raddrb_o,
    input  logic [31:0] rf_rdataa_i,
    input  logic [31:0] rf_rdatab_i,
    input  logic        wb_write_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        ex_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_rs1data_o,
    output logic [31:0] id_rs2data_o,
    output logic [31:0] id_imm_o,
    output logic [4:0]  id_rd_o
);

    logic        id_valid_q, id_valid_d;
    id_reg_t     id_q, id_d;

    logic [6:0]  if_opc;
    logic [4:0]  if_rs1, if_rs2;
    logic [31:0] if_imm;
    logic        load_held;
    logic        rs1_hit, rs2_hit;
    logic        stall;
    logic        xfer_in, xfer_out;

    assign if_opc = if_instr_i[6:0];
    assign if_rs1 = if_instr_i[19:15];
    assign if_rs2 = if_instr_i[24:20];

    assign rf_raddra_o = if_rs1;
    assign rf_raddrb_o = if_rs2;

    imm_gen u_imm_gen (
        .instr_i (if_instr_i),
        .imm_o   (if_imm)
    );

    // A load's result is not forwardable into decode, so a dependent offer waits one bubble.
    assign load_held = id_valid_q && (id_q.instr[6:0] == OPC_LOAD) && (id_q.rd != 5'd0);
    assign rs1_hit   = uses_rs1(if_opc) && (if_rs1 == id_q.rd);
    assign rs2_hit   = uses_rs2(if_opc) && (if_rs2 == id_q.rd);
    assign stall     = load_held && if_valid_i && (rs1_hit || rs2_hit);

    assign if_ready_o = (!id_valid_q || ex_ready_i) && !stall && !flush_i;
    assign xfer_in    = if_valid_i && if_ready_o;
    assign xfer_out   = id_valid_q && ex_ready_i;

    always_comb begin
        id_valid_d = id_valid_q;
        id_d       = id_q;
        if (flush_i) begin
            id_valid_d = 1'b0;
        end else if (xfer_in) begin
            id_valid_d    = 1'b1;
            id_d.pc       = if_pc_i;
            id_d.instr    = if_instr_i;
            id_d.rs1data  = sel_operand(if_rs1, wb_write_i, wb_waddr_i, wb_wdata_i, rf_rdataa_i);
            id_d.rs2data  = sel_operand(if_rs2, wb_write_i, wb_waddr_i, wb_wdata_i, rf_rdatab_i);
            id_d.imm      = if_imm;
            id_d.rd       = if_instr_i[11:7];
        end else if (xfer_out) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_valid_q <= 1'b0;
            id_q       <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_q       <= id_d;
        end
    end

    assign id_valid_o   = id_valid_q;
    assign id_pc_o      = id_q.pc;
    assign id_instr_o   = id_q.instr;
    assign id_rs1data_o = id_q.rs1data;
    assign id_rs2data_o = id_q.rs2data;
    assign id_imm_o     = id_q.imm;
    assign id_rd_o      = id_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-instruction decode vectors plus
// hand-written sequences for load-use stall, backpressure, flush and async reset.
module tb_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic [4:0]  rf_raddra_o;
    logic [4:0]  rf_raddrb_o;
    logic [31:0] rf_rdataa_i;
    logic [31:0] rf_rdatab_i;
    logic        wb_write_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        ex_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_rs1data_o;
    logic [31:0] id_rs2data_o;
    logic [31:0] id_imm_o;
    logic [4:0]  id_rd_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    decode_stage dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .if_valid_i   (if_valid_i),
        .if_ready_o   (if_ready_o),
        .if_instr_i   (if_instr_i),
        .if_pc_i      (if_pc_i),
        .rf_raddra_o  (rf_raddra_o),
        .rf_raddrb_o  (rf_raddrb_o),
        .rf_rdataa_i  (rf_rdataa_i),
        .rf_rdatab_i  (rf_rdatab_i),
        .wb_write_i   (wb_write_i),
        .wb_waddr_i   (wb_waddr_i),
        .wb_wdata_i   (wb_wdata_i),
        .ex_ready_i   (ex_ready_i),
        .id_valid_o   (id_valid_o),
        .id_pc_o      (id_pc_o),
        .id_instr_o   (id_instr_o),
        .id_rs1data_o (id_rs1data_o),
        .id_rs2data_o (id_rs2data_o),
        .id_imm_o     (id_imm_o),
        .id_rd_o      (id_rd_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rfa;
        logic [31:0] rfb;
        logic        wbw;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        if_valid_i = 1'b1;
        if_instr_i = instr;
        if_pc_i    = pc;
    endtask

    initial begin
        //        instr         pc          rfa           rfb           wbw   wba    wbd           ra     rb     rd     imm           rs1           rs2
        vecs[0]  = '{32'h00500093, 32'h1000, 32'h11111111, 32'h22222222, 1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd1,  32'h00000005, 32'h0,        32'h22222222};
        vecs[1]  = '{32'h002081B3, 32'h1004, 32'h00000000, 32'h12345678, 1'b1, 5'd1,  32'hDEADBEEF, 5'd1,  5'd2,  5'd3,  32'h00000000, 32'hDEADBEEF, 32'h12345678};
        vecs[2]  = '{32'hFE000EE3, 32'h1008, 32'h00000077, 32'h00000088, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 32'h0,        32'h0};
        vecs[3]  = '{32'hFE20AC23, 32'h100C, 32'hA5A5A5A5, 32'h00000000, 1'b1, 5'd2,  32'hCAFEF00D, 5'd1,  5'd2,  5'd24, 32'hFFFFFFF8, 32'hA5A5A5A5, 32'hCAFEF00D};
        vecs[4]  = '{32'hABCDE3B7, 32'h1010, 32'h00000001, 32'h00000002, 1'b0, 5'd0,  32'h0,        5'd27, 5'd28, 5'd7,  32'hABCDE000, 32'h1,        32'h2};
        vecs[5]  = '{32'h001000EF, 32'h1014, 32'h00000003, 32'h00000004, 1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  5'd1,  32'h00000800, 32'h0,        32'h4};
        vecs[6]  = '{32'h00C28067, 32'h1018, 32'h00000005, 32'h00000006, 1'b0, 5'd0,  32'h0,        5'd5,  5'd12, 5'd0,  32'h0000000C, 32'h5,        32'h6};
        vecs[7]  = '{32'hFFFFFFFF, 32'h101C, 32'h00000003, 32'h00000004, 1'b1, 5'd31, 32'h00005555, 5'd31, 5'd31, 5'd31, 32'h00000000, 32'h5555,     32'h5555};
        vecs[8]  = '{32'h00000033, 32'h1020, 32'h00000099, 32'h00000098, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h0,        32'h0};
        vecs[9]  = '{32'hFFFFF517, 32'h1024, 32'h0000AAAA, 32'h0000BBBB, 1'b1, 5'd30, 32'h00001234, 5'd31, 5'd31, 5'd10, 32'hFFFFF000, 32'hAAAA,     32'hBBBB};
        vecs[10] = '{32'hFFF00093, 32'h1028, 32'h00000007, 32'h00000008, 1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 5'd1,  32'hFFFFFFFF, 32'h0,        32'h8};

        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        if_valid_i  = 1'b0;
        if_instr_i  = 32'h0;
        if_pc_i     = 32'h0;
        rf_rdataa_i = 32'h0;
        rf_rdatab_i = 32'h0;
        wb_write_i  = 1'b0;
        wb_waddr_i  = 5'd0;
        wb_wdata_i  = 32'h0;
        ex_ready_i  = 1'b1;
        #12;
        rst_ni = 1'b1;
        #1;
        chk("reset id_valid", {31'd0, id_valid_o}, 32'd0);
        chk("reset id_instr", id_instr_o, 32'h0);
        chk("reset id_pc", id_pc_o, 32'h0);
        chk("reset id_imm", id_imm_o, 32'h0);
        chk("reset id_rd", {27'd0, id_rd_o}, 32'd0);
        chk("reset if_ready", {31'd0, if_ready_o}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            if_valid_i = 1'b0;
            wb_write_i = 1'b0;
            ex_ready_i = 1'b1;
            tick();
            offer(vecs[i].instr, vecs[i].pc);
            rf_rdataa_i = vecs[i].rfa;
            rf_rdatab_i = vecs[i].rfb;
            wb_write_i  = vecs[i].wbw;
            wb_waddr_i  = vecs[i].wba;
            wb_wdata_i  = vecs[i].wbd;
            #1;
            chk($sformatf("vec%0d if_ready", i), {31'd0, if_ready_o}, 32'd1);
            chk($sformatf("vec%0d raddra", i), {27'd0, rf_raddra_o}, {27'd0, vecs[i].ra});
            chk($sformatf("vec%0d raddrb", i), {27'd0, rf_raddrb_o}, {27'd0, vecs[i].rb});
            tick();
            if_valid_i = 1'b0;
            wb_write_i = 1'b0;
            chk($sformatf("vec%0d id_valid", i), {31'd0, id_valid_o}, 32'd1);
            chk($sformatf("vec%0d id_imm", i), id_imm_o, vecs[i].imm);
            chk($sformatf("vec%0d id_rd", i), {27'd0, id_rd_o}, {27'd0, vecs[i].rd});
            chk($sformatf("vec%0d id_rs1data", i), id_rs1data_o, vecs[i].rs1);
            chk($sformatf("vec%0d id_rs2data", i), id_rs2data_o, vecs[i].rs2);
            chk($sformatf("vec%0d id_pc", i), id_pc_o, vecs[i].pc);
            chk($sformatf("vec%0d id_instr", i), id_instr_o, vecs[i].instr);
        end

        // Load-use: LW x5 held, dependent ADD x6,x5,x5 gets exactly one bubble.
        rf_rdataa_i = 32'h0;
        rf_rdatab_i = 32'h0;
        tick();
        offer(32'h00002283, 32'h2000);
        tick();
        chk("lu lw held", id_instr_o, 32'h00002283);
        offer(32'h00528333, 32'h2004);
        #1;
        chk("lu stall if_ready", {31'd0, if_ready_o}, 32'd0);
        tick();
        chk("lu bubble id_valid", {31'd0, id_valid_o}, 32'd0);
        chk("lu retry if_ready", {31'd0, if_ready_o}, 32'd1);
        tick();
        chk("lu add id_valid", {31'd0, id_valid_o}, 32'd1);
        chk("lu add id_instr", id_instr_o, 32'h00528333);

        // Load followed by an offer that only has a matching unused rs2 field: no stall.
        offer(32'h00002283, 32'h2008);
        tick();
        offer(32'h00500313, 32'h200C);
        #1;
        chk("lu nouse if_ready", {31'd0, if_ready_o}, 32'd1);
        tick();
        chk("lu nouse id_instr", id_instr_o, 32'h00500313);

        // Load to x0 never stalls.
        offer(32'h00002003, 32'h2010);
        tick();
        offer(32'h00000333, 32'h2014);
        #1;
        chk("lu x0 if_ready", {31'd0, if_ready_o}, 32'd1);
        tick();
        chk("lu x0 id_instr", id_instr_o, 32'h00000333);

        // Execute backpressure for 3 cycles with a pending offer.
        offer(32'h00500313, 32'h3000);
        tick();
        ex_ready_i = 1'b0;
        offer(32'h00A00113, 32'h3004);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d if_ready", k), {31'd0, if_ready_o}, 32'd0);
            tick();
            chk($sformatf("bp%0d id_valid", k), {31'd0, id_valid_o}, 32'd1);
            chk($sformatf("bp%0d id_instr", k), id_instr_o, 32'h00500313);
            chk($sformatf("bp%0d id_pc", k), id_pc_o, 32'h3000);
        end
        ex_ready_i = 1'b1;
        #1;
        chk("bp release if_ready", {31'd0, if_ready_o}, 32'd1);
        tick();
        chk("bp release id_instr", id_instr_o, 32'h00A00113);
        chk("bp release id_imm", id_imm_o, 32'h0000000A);

        // Flush with a held instruction and a pending offer.
        ex_ready_i = 1'b0;
        flush_i    = 1'b1;
        offer(32'h00300193, 32'h4000);
        #1;
        chk("flush if_ready", {31'd0, if_ready_o}, 32'd0);
        tick();
        flush_i    = 1'b0;
        ex_ready_i = 1'b1;
        chk("flush id_valid", {31'd0, id_valid_o}, 32'd0);
        chk("flush not taken", id_instr_o, 32'h00A00113);
        tick();
        chk("post flush id_valid", {31'd0, id_valid_o}, 32'd1);
        chk("post flush id_instr", id_instr_o, 32'h00300193);

        // Asynchronous reset between clock edges.
        offer(32'hFE000EE3, 32'h5000);
        tick();
        chk("pre rst id_imm", id_imm_o, 32'hFFFFFFFC);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst id_valid", {31'd0, id_valid_o}, 32'd0);
        chk("async rst id_instr", id_instr_o, 32'h0);
        chk("async rst id_imm", id_imm_o, 32'h0);
        chk("async rst id_pc", id_pc_o, 32'h0);
        if_valid_i = 1'b0;
        #3;
        rst_ni = 1'b1;
        tick();
        chk("post rst if_ready", {31'd0, if_ready_o}, 32'd1);
        chk("post rst id_valid", {31'd0, id_valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk_i  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_ni  in  1  asynchronous, active-low reset.
REQ-003 flush_i  in  1  discard held and incoming instruction (branch/jump redirect).
REQ-004 if_valid_i  in  1  fetch offers an instruction.
REQ-005 if_ready_o  out  1  stage accepts the offered instruction this cycle.
REQ-006 if_instr_i  in  32  offered instruction word.
REQ-007 if_pc_i  in  32  PC of the offered instruction.
REQ-008 rf_raddra_o, rf_raddrb_o  out  5 each  register-file read addresses, equal to if_instr_i[19:15] and if_instr_i[24:20], combinational.
REQ-009 rf_rdataa_i, rf_rdatab_i  in  32 each  register-file read data, combinational, same cycle.
REQ-010 wb_write_i, wb_waddr_i, wb_wdata_i  in  1/5/32  writeback port, same signals that drive the register-file write port.
REQ-011 ex_ready_i  in  1  execute stage accepts id_* this cycle.
REQ-012 id_valid_o  out  1  ID/EX register holds a valid instruction.
REQ-013 id_pc_o, id_instr_o, id_rs1data_o, id_rs2data_o, id_imm_o  out  32 each  registered PC, instruction, operands, sign-extended immediate.
REQ-014 id_rd_o  out  5  registered destination register, instr[11:7].

Function
REQ-015 Transfer in: if_valid_i && if_ready_o; transfer out: id_valid_o && ex_ready_i.
REQ-016 if_ready_o = (!id_valid_o || ex_ready_i) && !stall && !flush_i, combinational.
REQ-017 On transfer in, all id_* load from the offered instruction and id_valid_o=1 next cycle; latency one cycle.
REQ-018 Transfer out without transfer in: id_valid_o=0 next cycle; id_* data hold otherwise.
REQ-019 id_* SHALL stay stable while id_valid_o && !ex_ready_i.
REQ-020 Operand select, per port: address 0 -> 0; else wb_write_i && wb_waddr_i==address -> wb_wdata_i (same-cycle write bypass); else register-file data.
REQ-021 rs1 used unless opcode LUI 0110111, AUIPC 0010111, JAL 1101111; rs2 used only for OP 0110011, STORE 0100011, BRANCH 1100011.
REQ-022 stall = id_valid_o && id_instr_o opcode LOAD 0000011 && id_rd_o!=0 && if_valid_i && a used source of the offered instruction equals id_rd_o.
REQ-023 On stall with ex_ready_i=1: load leaves, id_valid_o=0 next cycle (bubble), offer not accepted; offer accepted the following cycle.
REQ-024 Immediate: I (LOAD, OP-IMM 0010011, JALR 1100111), S, B, U, J formats per RV32I, sign-extended to 32 bits; other opcodes -> 0.
REQ-025 flush_i=1: id_valid_o=0 next cycle, no transfer in, regardless of ex_ready_i or stall.
REQ-026 No instruction validity checking; unknown opcodes pass through with imm 0.

Reset
REQ-027 rst_ni=0 asynchronously forces id_valid_o=0 and all id_* to 0; mid-transfer state discarded.
REQ-028 if_ready_o SHALL be 1 after reset release while flush_i=0.

Structure
REQ-029 Opcode constants and an immediate-format enum SHALL live in shared package rv32i_pkg.
REQ-030 Immediate generation SHALL be sub-module imm_gen (combinational, instr in, imm out).
REQ-031 ID/EX register is the only state; no other storage.

Verification
REQ-032 Reset, then ADDI x1,x0,5 (0x00500093) offered, ex_ready_i=1 -> next cycle id_valid_o=1, id_imm_o=5, id_rd_o=1, id_rs1data_o=0.
REQ-033 Offer ADD x3,x1,x2 while wb writes x1=0xDEADBEEF same cycle, regfile returns stale 0 -> id_rs1data_o=0xDEADBEEF.
REQ-034 LW x5,0(x0) held, offer ADD x6,x5,x5, ex_ready_i=1 -> one bubble (id_valid_o=0), ADD accepted one cycle later.
REQ-035 id_valid_o=1, ex_ready_i=0 for 3 cycles with new offers -> if_ready_o=0, id_* unchanged, no loss.
REQ-036 flush_i=1 with valid held and offer present -> id_valid_o=0 next cycle, offer not accepted.
REQ-037 BEQ with imm -4 (0xFE000EE3) -> id_imm_o=0xFFFFFFFC; rst_ni low mid-stream -> id_valid_o=0 immediately.
